player_ctrl_multi: RTL and testbench

//  Multi-track music sequencer control. Next-generation beat/track controller:
//  - Parametrised track count and beat-counter width.
//  - Per-track lengths supplied by the song ROM.
//  - Four loop modes, next/prev track navigation and a one-cycle end-of-track pulse.
//  - Single clock domain: beats advance on a beat_tick enable, not on a derived clock.

---
 rtl/player_ctrl_multi.sv | 147 ++++++++++++++
 tb/tb_player_ctrl_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl_multi.sv
// Multi-track sequencer control: play/pause/stop FSM, beat counter, track navigation, loop modes.
// Latency: every output is registered and reflects the qualifying input cycle one clk edge later.
// Backpressure: none; one-cycle command pulses are consumed or discarded in the cycle they arrive.
module player_ctrl_multi #(
    parameter int          NUM_TRACKS     = 4,
    parameter int          BEAT_W         = 8,
    parameter int          TRACK_W        = 2,
    parameter int unsigned RESTART_THRESH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               beat_tick,
    input  logic               play_pause,
    input  logic               stop,
    input  logic               next_trk,
    input  logic               prev_trk,
    input  logic [1:0]         loop_mode,
    input  logic [BEAT_W-1:0]  track_len,
    output logic               in_pause,
    output logic [BEAT_W-1:0]  ibeat,
    output logic [TRACK_W-1:0] track,
    output logic               track_end,
    output logic [1:0]         state_o
);

    localparam logic [1:0] ST_STOP    = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_PAUSE   = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    localparam logic [1:0] MODE_STOP    = 2'd0;
    localparam logic [1:0] MODE_REPEAT  = 2'd1;
    localparam logic [1:0] MODE_ADVANCE = 2'd2;

    localparam logic [TRACK_W-1:0] LAST_TRK = TRACK_W'(NUM_TRACKS - 1);

    logic [1:0]         state_q,     state_d;
    logic [BEAT_W-1:0]  ibeat_q,     ibeat_d;
    logic [TRACK_W-1:0] track_q,     track_d;
    logic               track_end_q, track_end_d;
    logic               in_pause_q,  in_pause_d;

    logic [BEAT_W-1:0]  len_eff;
    logic [BEAT_W-1:0]  last_beat;
    logic               at_last;
    logic               nav_next;
    logic               nav_prev;
    logic               restart_cur;
    logic [TRACK_W-1:0] track_inc;
    logic [TRACK_W-1:0] track_dec;

    // Zero-length tracks behave as one beat long; ">=" also catches a length that shrank under ibeat.
    assign len_eff   = (track_len == '0) ? BEAT_W'(1) : track_len;
    assign last_beat = len_eff - BEAT_W'(1);
    assign at_last   = (ibeat_q >= last_beat);

    // Simultaneous next/prev cancel each other and let lower-priority events through.
    assign nav_next    = next_trk & ~prev_trk;
    assign nav_prev    = prev_trk & ~next_trk;
    assign restart_cur = (32'(ibeat_q) >= RESTART_THRESH);

    // Track index wraps modulo NUM_TRACKS, which need not be a power of two.
    assign track_inc = (track_q == LAST_TRK) ? '0 : track_q + TRACK_W'(1);
    assign track_dec = (track_q == '0) ? LAST_TRK : track_q - TRACK_W'(1);

    // Next-state: stop > navigation > play_pause > beat_tick; losers in a cycle are dropped.
    always_comb begin
        state_d     = state_q;
        ibeat_d     = ibeat_q;
        track_d     = track_q;
        track_end_d = 1'b0;

        if (stop) begin
            state_d = ST_STOP;
            ibeat_d = '0;
        end else if (state_q == ST_ILLEGAL) begin
            state_d = ST_STOP;
            ibeat_d = '0;
        end else if (nav_next) begin
            track_d = track_inc;
            ibeat_d = '0;
        end else if (nav_prev) begin
            // Late in a track, "previous" means restart the current one.
            if (!restart_cur) begin
                track_d = track_dec;
            end
            ibeat_d = '0;
        end else if (play_pause) begin
            // Beat position is kept across pause/resume; STOP already sits at beat 0.
            case (state_q)
                ST_PLAY: state_d = ST_PAUSE;
                default: state_d = ST_PLAY;
            endcase
        end else if (beat_tick && (state_q == ST_PLAY)) begin
            if (at_last) begin
                track_end_d = 1'b1;
                ibeat_d     = '0;
                case (loop_mode)
                    MODE_STOP: begin
                        state_d = ST_STOP;
                    end
                    MODE_REPEAT: begin
                        state_d = ST_PLAY;
                    end
                    MODE_ADVANCE: begin
                        if (track_q == LAST_TRK) begin
                            state_d = ST_STOP;
                        end else begin
                            track_d = track_q + TRACK_W'(1);
                        end
                    end
                    default: begin
                        track_d = track_inc;
                    end
                endcase
            end else begin
                ibeat_d = ibeat_q + BEAT_W'(1);
            end
        end

        in_pause_d = (state_d != ST_PLAY);
    end

    // Control registers, cleared asynchronously so a reset mid-play silences the player at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_STOP;
            ibeat_q     <= '0;
            track_q     <= '0;
            track_end_q <= 1'b0;
            in_pause_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            ibeat_q     <= ibeat_d;
            track_q     <= track_d;
            track_end_q <= track_end_d;
            in_pause_q  <= in_pause_d;
        end
    end

    assign state_o   = state_q;
    assign ibeat     = ibeat_q;
    assign track     = track_q;
    assign track_end = track_end_q;
    assign in_pause  = in_pause_q;

endmodule

// File: tb/tb_player_ctrl_multi.sv
// Bench for player_ctrl_multi: directed scenarios with fixed expectations, then random traffic.
// Latency: outputs checked 1 time unit after the clk edge that consumed the inputs.
// Backpressure: not applicable.
module tb_player_ctrl_multi;

    localparam int NT  = 4;
    localparam int THR = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beat_tick = 1'b0;
    logic       play_pause = 1'b0;
    logic       stop = 1'b0;
    logic       next_trk = 1'b0;
    logic       prev_trk = 1'b0;
    logic [1:0] loop_mode = 2'd0;
    logic [7:0] track_len = 8'd4;
    logic       in_pause;
    logic [7:0] ibeat;
    logic [1:0] track;
    logic       track_end;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: state 0 STOP, 1 PLAY, 2 PAUSE
    int m_state, m_beat, m_track;
    bit m_end;

    player_ctrl_multi #(
        .NUM_TRACKS(NT), .BEAT_W(8), .TRACK_W(2), .RESTART_THRESH(THR)
    ) dut (
        .clk(clk), .reset(reset), .beat_tick(beat_tick), .play_pause(play_pause),
        .stop(stop), .next_trk(next_trk), .prev_trk(prev_trk), .loop_mode(loop_mode),
        .track_len(track_len), .in_pause(in_pause), .ibeat(ibeat), .track(track),
        .track_end(track_end), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] dut_vec();
        return {state_o, ibeat, track, track_end, in_pause};
    endfunction

    function automatic logic [13:0] exp_vec(input int st, input int ib, input int tr, input bit te);
        return {2'(st), 8'(ib), 2'(tr), te, (st != 1)};
    endfunction

    function automatic logic [13:0] mdl_vec();
        return exp_vec(m_state, m_beat, m_track, m_end);
    endfunction

    task automatic model_reset();
        m_state = 0; m_beat = 0; m_track = 0; m_end = 0;
    endtask

    // Behavioural rules: one event wins per cycle, in priority order.
    task automatic model_step(input bit st, pp, nx, pv, bt, input int mode, input int len);
        int last;
        last  = ((len == 0) ? 1 : len) - 1;
        m_end = 0;
        if (st) begin
            m_state = 0; m_beat = 0;
        end else if (nx && !pv) begin
            m_track = (m_track + 1) % NT; m_beat = 0;
        end else if (pv && !nx) begin
            if (m_beat < THR) m_track = (m_track + NT - 1) % NT;
            m_beat = 0;
        end else if (pp) begin
            m_state = (m_state == 1) ? 2 : 1;
        end else if (bt && m_state == 1) begin
            if (m_beat >= last) begin
                m_end  = 1;
                m_beat = 0;
                case (mode)
                    0: m_state = 0;
                    1: ;
                    2: if (m_track < NT - 1) m_track = m_track + 1; else m_state = 0;
                    default: m_track = (m_track + 1) % NT;
                endcase
            end else begin
                m_beat = m_beat + 1;
            end
        end
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic drive(input bit st, pp, nx, pv, bt);
        stop = st; play_pause = pp; next_trk = nx; prev_trk = pv; beat_tick = bt;
        @(posedge clk);
        model_step(st, pp, nx, pv, bt, int'(loop_mode), int'(track_len));
        #1;
        stop = 0; play_pause = 0; next_trk = 0; prev_trk = 0; beat_tick = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 0, 0)) begin
            n_err++; $display("FAIL reset_values got=%h exp=%h", dut_vec(), exp_vec(0, 0, 0, 0));
        end
        reset = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 0, 0)) begin
            n_err++; $display("FAIL stop_ignores_tick got=%h exp=%h", dut_vec(), exp_vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_basic();
        track_len = 8'd4; loop_mode = 2'd0;
        drive(0, 1, 0, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 0, 0)) begin
            n_err++; $display("FAIL basic_start got=%h exp=%h", dut_vec(), exp_vec(1, 0, 0, 0));
        end
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++;
            if (dut_vec() !== exp_vec(1, i, 0, 0)) begin
                n_err++; $display("FAIL basic_tick%0d got=%h exp=%h", i, dut_vec(), exp_vec(1, i, 0, 0));
            end
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 0, 1)) begin
            n_err++; $display("FAIL basic_end got=%h exp=%h", dut_vec(), exp_vec(0, 0, 0, 1));
        end
        drive(0, 0, 0, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 0, 0)) begin
            n_err++; $display("FAIL basic_end_one_cycle got=%h exp=%h", dut_vec(), exp_vec(0, 0, 0, 0));
        end
    endtask

    task automatic test_wrap();
        repeat (3) drive(0, 0, 1, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 3, 0)) begin
            n_err++; $display("FAIL wrap_nav_in_stop got=%h exp=%h", dut_vec(), exp_vec(0, 0, 3, 0));
        end
        loop_mode = 2'd3; track_len = 8'd1;
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 0, 1)) begin
            n_err++; $display("FAIL wrap_mode3 got=%h exp=%h", dut_vec(), exp_vec(1, 0, 0, 1));
        end
        loop_mode = 2'd2;
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 3, 0)) begin
            n_err++; $display("FAIL wrap_prev_from0 got=%h exp=%h", dut_vec(), exp_vec(1, 0, 3, 0));
        end
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 3, 1)) begin
            n_err++; $display("FAIL wrap_mode2_last got=%h exp=%h", dut_vec(), exp_vec(0, 0, 3, 1));
        end
    endtask

    task automatic test_pause();
        track_len = 8'd20; loop_mode = 2'd0;
        drive(0, 1, 0, 0, 0);
        repeat (5) drive(0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(2, 5, 3, 0)) begin
            n_err++; $display("FAIL pause_drop_tick got=%h exp=%h", dut_vec(), exp_vec(2, 5, 3, 0));
        end
        repeat (3) drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(2, 5, 3, 0)) begin
            n_err++; $display("FAIL pause_hold got=%h exp=%h", dut_vec(), exp_vec(2, 5, 3, 0));
        end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 6, 3, 0)) begin
            n_err++; $display("FAIL pause_resume got=%h exp=%h", dut_vec(), exp_vec(1, 6, 3, 0));
        end
    endtask

    task automatic test_nav();
        drive(0, 0, 1, 0, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 0, 0)) begin
            n_err++; $display("FAIL nav_next_wrap got=%h exp=%h", dut_vec(), exp_vec(1, 0, 0, 0));
        end
        repeat (2) drive(0, 0, 1, 0, 0);
        repeat (10) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 2, 0)) begin
            n_err++; $display("FAIL nav_prev_restart got=%h exp=%h", dut_vec(), exp_vec(1, 0, 2, 0));
        end
        repeat (2) drive(0, 0, 1, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 3, 0)) begin
            n_err++; $display("FAIL nav_prev_back got=%h exp=%h", dut_vec(), exp_vec(1, 0, 3, 0));
        end
        repeat (2) drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 3, 3, 0)) begin
            n_err++; $display("FAIL nav_both_tick got=%h exp=%h", dut_vec(), exp_vec(1, 3, 3, 0));
        end
        drive(0, 0, 1, 1, 0);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 3, 3, 0)) begin
            n_err++; $display("FAIL nav_both_idle got=%h exp=%h", dut_vec(), exp_vec(1, 3, 3, 0));
        end
    endtask

    task automatic test_shrink();
        track_len = 8'd30; loop_mode = 2'd1;
        repeat (17) drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 20, 3, 0)) begin
            n_err++; $display("FAIL shrink_setup got=%h exp=%h", dut_vec(), exp_vec(1, 20, 3, 0));
        end
        track_len = 8'd10;
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(1, 0, 3, 1)) begin
            n_err++; $display("FAIL shrink_end got=%h exp=%h", dut_vec(), exp_vec(1, 0, 3, 1));
        end
        track_len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1);
            n_cmp++;
            if (dut_vec() !== exp_vec(1, 0, 3, 1)) begin
                n_err++; $display("FAIL len0_end%0d got=%h exp=%h", i, dut_vec(), exp_vec(1, 0, 3, 1));
            end
        end
        loop_mode = 2'd0;
        drive(0, 0, 0, 0, 1);
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 3, 1)) begin
            n_err++; $display("FAIL len0_mode0 got=%h exp=%h", dut_vec(), exp_vec(0, 0, 3, 1));
        end
    endtask

    task automatic test_midplay_reset();
        track_len = 8'd20;
        drive(0, 1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== exp_vec(0, 0, 0, 0)) begin
            n_err++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), exp_vec(0, 0, 0, 0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) track_len = 8'($urandom_range(0, 20));
            if ($urandom_range(0, 31) == 0) loop_mode = 2'($urandom_range(0, 3));
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 55);
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_err++;
                $display("FAIL random_cycle%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_pause();
        test_nav();
        test_shrink();
        test_midplay_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
